// File: rtl/io_port_ctrl_pkg.sv
// Shared I/O decode constants and stop-FSM encodings for io_port_ctrl.
package io_port_ctrl_pkg;

  localparam logic [1:0] IO_SEL  = 2'b11;
  localparam logic [2:0] IO_UART = 3'h0;
  localparam logic [2:0] IO_CLK  = 3'h4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STOP  = 2'd2
  } stop_state_e;

endpackage

// File: rtl/io_tx_fifo.sv
// TX byte FIFO: power-of-two depth, naturally wrapping pointers, occupancy count.
module io_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    next_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign next_count = count + CW'(do_push) - CW'(do_pop);
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign dout       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= next_count;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-bus splitter behind the cpu: RAM pass-through, UART TX/RX, cycle counter and stop control.
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(TX_DEPTH - FULL_MARGIN);

  logic          is_io;
  logic          io_hit;
  logic [2:0]    io_off;
  logic          uart_wr;
  logic          uart_rd;
  logic          clk_wr;
  logic          clk_rd;
  logic          push_req;
  logic          push_ok;
  logic          tx_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_next_count;
  logic [7:0]    io_rd_c;

  logic          src_q;
  logic [7:0]    io_rd_q;
  logic [31:0]   cnt_q;
  logic [23:0]   snap_q;
  logic          ovf_q;
  stop_state_e   state_q;

  logic          unused_bits;
  assign unused_bits = ^{cpu_a[31:18], fifo_count};

  assign is_io   = (cpu_a[17:16] == IO_SEL);
  assign io_hit  = is_io & (cpu_a[15:3] == '0);
  assign io_off  = cpu_a[2:0];
  assign uart_wr = io_hit &  cpu_wr & (io_off == IO_UART);
  assign uart_rd = io_hit & ~cpu_wr & (io_off == IO_UART);
  assign clk_wr  = io_hit &  cpu_wr & (io_off == IO_CLK);
  assign clk_rd  = io_hit & ~cpu_wr & (io_off == IO_CLK);

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = cpu_wr & ~is_io & ~rst_in;

  // src_q resets to the I/O side so cpu_din reads 0 while in reset.
  assign cpu_din = src_q ? io_rd_q : ram_din;

  assign tx_valid = ~fifo_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign push_req = uart_wr & (cpu_dout != 8'h00) & (state_q == ST_RUN);
  assign push_ok  = push_req & (~fifo_full | tx_pop);
  assign rx_pop   = uart_rd & rx_valid & ~rst_in;

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (push_ok),
    .pop        (tx_pop),
    .din        (cpu_dout),
    .dout       (tx_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .next_count (fifo_next_count)
  );

  // I/O read data selection; counter high bytes come from the snapshot for tear-free reads.
  always_comb begin
    io_rd_c = 8'h00;
    if (io_hit && !cpu_wr) begin
      case (io_off)
        IO_UART: io_rd_c = rx_valid ? rx_data : 8'h00;
        IO_CLK:  io_rd_c = cnt_q[7:0];
        3'h5:    io_rd_c = snap_q[7:0];
        3'h6:    io_rd_c = snap_q[15:8];
        3'h7:    io_rd_c = snap_q[23:16];
        default: io_rd_c = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q          <= 1'b1;
      io_rd_q        <= 8'h00;
      cnt_q          <= 32'h0;
      snap_q         <= 24'h0;
      ovf_q          <= 1'b0;
      io_buffer_full <= 1'b0;
      program_stop   <= 1'b0;
      state_q        <= ST_RUN;
    end else begin
      src_q          <= is_io;
      io_rd_q        <= io_rd_c;
      io_buffer_full <= (fifo_next_count >= FULL_LVL);
      if (rdy_in)              cnt_q  <= cnt_q + 32'd1;
      if (clk_rd)              snap_q <= cnt_q[31:8];
      if (push_req && !push_ok) ovf_q <= 1'b1;

      case (state_q)
        ST_RUN: begin
          if (clk_wr) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q      <= ST_STOP;
            program_stop <= 1'b1;
          end
        end
        ST_STOP: begin
          program_stop <= 1'b1;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl with a small registered RAM model.
module tb_io_port_ctrl;
  import io_port_ctrl_pkg::*;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram_mem [256];

  io_port_ctrl #(.TX_DEPTH(8), .FULL_MARGIN(2)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .ram_a          (ram_a),
    .ram_dout       (ram_dout),
    .ram_we         (ram_we),
    .ram_din        (ram_din),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a[7:0]] <= ram_dout;
    ram_din <= ram_mem[ram_a[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a    = a;
    cpu_dout = d;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
    cpu_a    = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    cpu_a  = a;
    cpu_wr = 1'b0;
    tick();
    cpu_a  = 32'h0;
  endtask

  initial begin
    int pops;
    int stop_cyc;
    rst_in   = 1'b1;
    rdy_in   = 1'b0;
    cpu_a    = 32'h0003_0000;
    cpu_dout = 8'h00;
    cpu_wr   = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    ram_din  = 8'h00;
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;

    // Reset values
    tick();
    tick();
    chk("rst_cpu_din", 32'(cpu_din), 32'h00);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_ibf", 32'(io_buffer_full), 32'h0);
    chk("rst_stop", 32'(program_stop), 32'h0);
    chk("rst_rx_pop", 32'(rx_pop), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_RUN));
    rst_in   = 1'b0;
    rx_valid = 1'b0;
    cpu_a    = 32'h0;
    tick();

    // RAM write then read
    cpu_a = 32'h0000_0010; cpu_dout = 8'hA5; cpu_wr = 1'b1;
    #1 chk("ram_we_wr", 32'(ram_we), 32'h1);
    tick();
    cpu_wr = 1'b0;
    #1 chk("ram_we_rd", 32'(ram_we), 32'h0);
    tick();
    chk("ram_rd_data", 32'(cpu_din), 32'hA5);
    cpu_a = 32'h0;

    // TX fill with the UART stalled
    for (int i = 0; i < 6; i++) begin
      bus_wr(32'h0003_0000, 8'(8'h41 + i));
      if (i == 4) chk("ibf_at5", 32'(io_buffer_full), 32'h0);
    end
    chk("ibf_at6", 32'(io_buffer_full), 32'h1);
    bus_wr(32'h0003_0000, 8'h00);
    chk("zero_wr_count", 32'(dut.u_fifo.count), 32'd6);
    bus_wr(32'h0003_0000, 8'h47);
    bus_wr(32'h0003_0000, 8'h48);
    chk("ovf_before", 32'(dut.ovf_q), 32'h0);
    bus_wr(32'h0003_0000, 8'h49);
    chk("full_count", 32'(dut.u_fifo.count), 32'd8);
    chk("ovf_after", 32'(dut.ovf_q), 32'h1);

    // Drain in order
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(tx_valid), 32'h1);
      chk("drain_data", 32'(tx_data), 32'(8'h41 + i));
      tick();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    chk("drain_ibf", 32'(io_buffer_full), 32'h0);
    tx_ready = 1'b0;

    // RX with and without a byte available
    rx_data = 8'h5A; rx_valid = 1'b1; cpu_a = 32'h0003_0000; cpu_wr = 1'b0;
    #1 chk("rx_pop_hi", 32'(rx_pop), 32'h1);
    tick();
    cpu_a = 32'h0; rx_valid = 1'b0; rx_data = 8'h77;
    #1 chk("rx_pop_lo", 32'(rx_pop), 32'h0);
    chk("rx_data", 32'(cpu_din), 32'h5A);
    cpu_a = 32'h0003_0000;
    #1 chk("rx_nopop", 32'(rx_pop), 32'h0);
    tick();
    cpu_a = 32'h0;
    chk("rx_empty_data", 32'(cpu_din), 32'h00);

    // Cycle counter and snapshot reads
    rdy_in = 1'b1;
    repeat (32'h1234) tick();
    rdy_in = 1'b0;
    bus_rd(32'h0003_0004); chk("cnt_b0", 32'(cpu_din), 32'h34);
    bus_rd(32'h0003_0005); chk("cnt_b1", 32'(cpu_din), 32'h12);
    bus_rd(32'h0003_0002); chk("io_other_rd", 32'(cpu_din), 32'h00);
    bus_rd(32'h0003_0006); chk("cnt_b2", 32'(cpu_din), 32'h00);
    bus_rd(32'h0003_0007); chk("cnt_b3", 32'(cpu_din), 32'h00);
    repeat (5) tick();
    bus_rd(32'h0003_0004); chk("cnt_frozen", 32'(cpu_din), 32'h34);
    rdy_in = 1'b1;
    repeat (8'hCB) tick();
    bus_rd(32'h0003_0004); chk("cnt_tear_b0", 32'(cpu_din), 32'hFF);
    bus_rd(32'h0003_0005); chk("cnt_tear_b1", 32'(cpu_din), 32'h12);
    rdy_in = 1'b0;
    bus_rd(32'h0003_0004); chk("cnt_moved", 32'(cpu_din), 32'h01);

    bus_wr(32'h0003_0002, 8'h55);
    chk("io_other_wr", 32'(tx_valid), 32'h0);

    // Stop with 3 queued bytes and a half-rate UART
    bus_wr(32'h0003_0000, 8'h61);
    bus_wr(32'h0003_0000, 8'h62);
    bus_wr(32'h0003_0000, 8'h63);
    bus_wr(32'h0003_0004, 8'h00);
    chk("stop_drain_state", 32'(dut.state_q), 32'(ST_DRAIN));
    chk("stop_not_yet", 32'(program_stop), 32'h0);
    pops = 0;
    stop_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      tx_ready = (c % 2) == 1;
      if (tx_valid && tx_ready) begin
        chk("stop_data", 32'(tx_data), 32'(8'h61 + pops));
        pops++;
      end
      tick();
      if (program_stop && stop_cyc < 0) stop_cyc = c;
    end
    tx_ready = 1'b0;
    chk("stop_pops", 32'(pops), 32'd3);
    chk("stop_rise_cyc", 32'(stop_cyc), 32'd6);
    bus_wr(32'h0003_0000, 8'h77);
    chk("stop_no_push", 32'(tx_valid), 32'h0);
    chk("stop_sticky", 32'(program_stop), 32'h1);

    // Reset in the middle of a drain
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 6; i++) bus_wr(32'h0003_0000, 8'(8'h21 + i));
    chk("mid_ibf", 32'(io_buffer_full), 32'h1);
    bus_wr(32'h0003_0004, 8'h00);
    chk("mid_state", 32'(dut.state_q), 32'(ST_DRAIN));
    rst_in = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_ibf", 32'(io_buffer_full), 32'h0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_RUN));
    chk("mid_rst_stop", 32'(program_stop), 32'h0);
    rst_in = 1'b0;
    tick();
    bus_wr(32'h0003_0000, 8'h99);
    chk("post_rst_push", 32'(tx_data), 32'h99);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("post_rst_drained", 32'(tx_valid), 32'h0);

    // Stop with the FIFO already empty: one DRAIN cycle
    bus_wr(32'h0003_0004, 8'h00);
    chk("empty_stop_drain", 32'(program_stop), 32'h0);
    tick();
    chk("empty_stop_done", 32'(program_stop), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
